// File: rtl/io_out_buffer.sv
// io_out_buffer: memory-mapped character output buffer.
// CPU writes at offset 0 queue a byte into a circular FIFO; a write at offset 4
// requests program end. Bytes drain through a single output register over a
// valid/ready stream, and done_out rises once everything has been handed off.
module io_out_buffer #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  io_wr_in,
    input  logic [2:0]            io_addr_in,
    input  logic [7:0]            io_data_in,
    output logic                  io_full_out,
    output logic [7:0]            tx_data_out,
    output logic                  tx_valid_out,
    input  logic                  tx_ready_in,
    output logic [DEPTH_LOG2:0]   count_out,
    output logic                  overflow_out,
    output logic                  done_out
);

    localparam int DATA_W = 8;
    localparam int DEPTH  = 1 << DEPTH_LOG2;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [DEPTH_LOG2:0]   FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0]     mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr;
    logic [DEPTH_LOG2-1:0] rptr;
    logic [DEPTH_LOG2:0]   count;
    logic [1:0]            state;

    // Output register stage
    logic [DATA_W-1:0]     data_p1;
    logic                  vld_p1;

    logic char_wr;
    logic end_wr;
    logic is_full;
    logic push;
    logic drop;
    logic pop;
    logic out_clear;
    logic drained;

    // Decode the CPU write and the stream handshake for this cycle.
    always_comb begin
        char_wr   = rdy_in && io_wr_in && (io_addr_in == 3'd0);
        end_wr    = rdy_in && io_wr_in && (io_addr_in == 3'd4);
        is_full   = (count == FULL_CNT);
        // No bypass at full: a write while full is dropped even if a pop happens.
        push      = char_wr && (state == ST_RUN) && !is_full;
        drop      = char_wr && ((state != ST_RUN) || is_full);
        pop       = rdy_in && (count != '0) && (!vld_p1 || tx_ready_in);
        out_clear = rdy_in && vld_p1 && tx_ready_in && (count == '0);
        drained   = (count == '0) && !vld_p1;
    end

    // FIFO storage write; contents need no reset because count gates reads.
    always_ff @(posedge clk_in) begin
        if (push) begin
            mem[wptr] <= io_data_in;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + PTR_ONE;
            end
            if (pop) begin
                rptr <= rptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Output register: load the head byte, clear on the last handshake, else hold.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            data_p1 <= '0;
            vld_p1  <= 1'b0;
        end else if (pop) begin
            data_p1 <= mem[rptr];
            vld_p1  <= 1'b1;
        end else if (out_clear) begin
            vld_p1  <= 1'b0;
        end
    end

    // Program-end state machine: RUN -> DRAIN -> DONE (terminal until reset).
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= ST_RUN;
        end else if (rdy_in) begin
            case (state)
                ST_RUN:   if (end_wr)  state <= ST_DRAIN;
                ST_DRAIN: if (drained) state <= ST_DONE;
                ST_DONE:  state <= ST_DONE;
                default:  state <= ST_RUN;
            endcase
        end
    end

    // Sticky status flags; done_out follows the DONE state by one edge.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            overflow_out <= 1'b0;
            done_out     <= 1'b0;
        end else if (rdy_in) begin
            if (drop) begin
                overflow_out <= 1'b1;
            end
            if (state == ST_DONE) begin
                done_out <= 1'b1;
            end
        end
    end

    assign io_full_out  = is_full;
    assign count_out    = count;
    assign tx_data_out  = data_p1;
    assign tx_valid_out = vld_p1;

endmodule

// File: tb/tb_io_out_buffer.sv
// Testbench for io_out_buffer: directed stimulus, a byte scoreboard fed by the
// stimulus, and a monitor that checks every completed stream handshake.
module tb_io_out_buffer;

    localparam int DEPTH_LOG2 = 4;

    logic                clk_in = 1'b0;
    logic                rst_in = 1'b1;
    logic                rdy_in = 1'b1;
    logic                io_wr_in = 1'b0;
    logic [2:0]          io_addr_in = 3'd0;
    logic [7:0]          io_data_in = 8'd0;
    logic                io_full_out;
    logic [7:0]          tx_data_out;
    logic                tx_valid_out;
    logic                tx_ready_in = 1'b0;
    logic [DEPTH_LOG2:0] count_out;
    logic                overflow_out;
    logic                done_out;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    io_out_buffer #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .io_wr_in     (io_wr_in),
        .io_addr_in   (io_addr_in),
        .io_data_in   (io_data_in),
        .io_full_out  (io_full_out),
        .tx_data_out  (tx_data_out),
        .tx_valid_out (tx_valid_out),
        .tx_ready_in  (tx_ready_in),
        .count_out    (count_out),
        .overflow_out (overflow_out),
        .done_out     (done_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Single-cycle CPU write; the write is sampled on the next rising edge.
    task automatic wr(input logic [2:0] addr, input logic [7:0] data);
        io_wr_in   = 1'b1;
        io_addr_in = addr;
        io_data_in = data;
        tick();
        io_wr_in   = 1'b0;
    endtask

    task automatic do_reset();
        tx_ready_in = 1'b0;
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        exp_q.delete();
    endtask

    // Monitor: each handshake that will complete on the next edge must match the scoreboard head.
    always @(negedge clk_in) begin
        if (!rst_in && rdy_in && tx_valid_out && tx_ready_in) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL tx_unexpected: got 0x%0h expected no byte", tx_data_out);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (tx_data_out !== e) begin
                    errors++;
                    $display("FAIL tx_byte: got 0x%0h expected 0x%0h", tx_data_out, e);
                end
            end
        end
    end

    initial begin
        // Reset values
        tick();
        rst_in = 1'b0;
        chk("rst_valid", 32'(tx_valid_out), 32'd0);
        chk("rst_data", 32'(tx_data_out), 32'd0);
        chk("rst_count", 32'(count_out), 32'd0);
        chk("rst_full", 32'(io_full_out), 32'd0);
        chk("rst_ovf", 32'(overflow_out), 32'd0);
        chk("rst_done", 32'(done_out), 32'd0);

        // Single byte with ready held high
        tx_ready_in = 1'b1;
        exp_q.push_back(8'h41);
        wr(3'd0, 8'h41);
        chk("single_cnt_e", 32'(count_out), 32'd1);
        chk("single_vld_e", 32'(tx_valid_out), 32'd0);
        tick();
        chk("single_vld_e1", 32'(tx_valid_out), 32'd1);
        chk("single_data_e1", 32'(tx_data_out), 32'h41);
        chk("single_cnt_e1", 32'(count_out), 32'd0);
        tick();
        chk("single_vld_e2", 32'(tx_valid_out), 32'd0);
        chk("single_sb_empty", 32'(exp_q.size()), 32'd0);

        // Back-pressure: fill output register plus 16 FIFO entries
        do_reset();
        for (int i = 0; i <= 16; i++) begin
            exp_q.push_back(8'(i));
            wr(3'd0, 8'(i));
        end
        chk("bp_full", 32'(io_full_out), 32'd1);
        chk("bp_count", 32'(count_out), 32'd16);
        chk("bp_ovf0", 32'(overflow_out), 32'd0);
        chk("bp_head", 32'(tx_data_out), 32'h00);
        wr(3'd0, 8'hEE);
        chk("bp_ovf1", 32'(overflow_out), 32'd1);
        chk("bp_count_drop", 32'(count_out), 32'd16);
        tx_ready_in = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        chk("bp_drain_cnt", 32'(count_out), 32'd0);
        chk("bp_drain_vld", 32'(tx_valid_out), 32'd0);
        chk("bp_sb_empty", 32'(exp_q.size()), 32'd0);

        // Simultaneous push/pop: steady writes with ready high
        do_reset();
        tx_ready_in = 1'b1;
        io_wr_in = 1'b1;
        io_addr_in = 3'd0;
        for (int i = 0; i < 8; i++) begin
            io_data_in = 8'(8'hA0 + i);
            exp_q.push_back(8'(8'hA0 + i));
            tick();
            chk("pp_count", 32'(count_out), 32'd1);
        end
        io_wr_in = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("pp_count_end", 32'(count_out), 32'd0);
        chk("pp_sb_empty", 32'(exp_q.size()), 32'd0);

        // Program end with pending bytes, then a late character write
        do_reset();
        exp_q.push_back(8'h4F);
        wr(3'd0, 8'h4F);
        exp_q.push_back(8'h4B);
        wr(3'd0, 8'h4B);
        wr(3'd4, 8'h00);
        wr(3'd0, 8'h58);
        chk("end_ovf", 32'(overflow_out), 32'd1);
        chk("end_count", 32'(count_out), 32'd1);
        chk("end_done0", 32'(done_out), 32'd0);
        tx_ready_in = 1'b1;
        begin
            int n = 0;
            while (!done_out && n < 12) begin
                tick();
                n++;
            end
        end
        chk("end_done1", 32'(done_out), 32'd1);
        chk("end_sb_empty", 32'(exp_q.size()), 32'd0);

        // Program end on an empty buffer: done two edges after the write edge
        do_reset();
        wr(3'd4, 8'h00);
        chk("end_empty_w", 32'(done_out), 32'd0);
        tick();
        chk("end_empty_w1", 32'(done_out), 32'd0);
        tick();
        chk("end_empty_w2", 32'(done_out), 32'd1);
        chk("end_empty_ovf", 32'(overflow_out), 32'd0);

        // Pause: rdy_in low freezes everything even with ready high
        do_reset();
        exp_q.push_back(8'h51);
        wr(3'd0, 8'h51);
        exp_q.push_back(8'h52);
        wr(3'd0, 8'h52);
        exp_q.push_back(8'h53);
        wr(3'd0, 8'h53);
        rdy_in = 1'b0;
        tx_ready_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("pause_vld", 32'(tx_valid_out), 32'd1);
            chk("pause_data", 32'(tx_data_out), 32'h51);
            chk("pause_count", 32'(count_out), 32'd2);
        end
        rdy_in = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("pause_cnt_end", 32'(count_out), 32'd0);
        chk("pause_sb_empty", 32'(exp_q.size()), 32'd0);

        // Reset mid-drain with 5 bytes queued
        do_reset();
        for (int i = 0; i < 5; i++) wr(3'd0, 8'(8'h60 + i));
        chk("rmd_count_pre", 32'(count_out), 32'd4);
        do_reset();
        chk("rmd_valid", 32'(tx_valid_out), 32'd0);
        chk("rmd_data", 32'(tx_data_out), 32'd0);
        chk("rmd_count", 32'(count_out), 32'd0);
        chk("rmd_full", 32'(io_full_out), 32'd0);
        tx_ready_in = 1'b1;
        exp_q.push_back(8'h77);
        wr(3'd0, 8'h77);
        chk("rmd_cnt_e", 32'(count_out), 32'd1);
        tick();
        chk("rmd_vld_e1", 32'(tx_valid_out), 32'd1);
        chk("rmd_data_e1", 32'(tx_data_out), 32'h77);
        tick();
        chk("rmd_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/io_out_buffer.md
# io_out_buffer

Memory-mapped output buffer between the CPU's I/O write port and the host-communication byte transmitter inside `riscv_top`. It accepts character writes (offset 0) and a program-end request (offset 4), queues the characters in a FIFO and drains them over a valid/ready byte stream. It signals `done_out` only after every queued byte has been handed off, so the simulation bench can stop cleanly.

## Interface
- `DEPTH_LOG2`, default 4: FIFO depth is 2^DEPTH_LOG2 entries. This is 16 by default; legal range is 2..8.

Ports:
- `clk_in` in 1: the single clock; all state changes on its rising edge.
- `rst_in` in 1: reset, synchronous and active-high.
- `rdy_in` in 1: global enable; when low, no state changes (handshakes included).
- `io_wr_in` in 1: CPU I/O write strobe, one cycle per write.
- `io_addr_in` in 3: I/O address offset; 0 is a character, 4 is program end, others are ignored.
- `io_data_in` in 8: character byte (unused for offset 4).
- `io_full_out` out 1: FIFO full; the CPU must stall its character writes.
- `tx_data_out` out 8: byte to transmitter.
- `tx_valid_out` out 1: `tx_data_out` holds a valid byte.
- `tx_ready_in` in 1: transmitter accepts the byte this cycle.
- `count_out` out DEPTH_LOG2+1: FIFO occupancy, excluding the output register.
- `overflow_out` out 1: sticky error; a character write was dropped.
- `done_out` out 1: sticky; the program ended and all bytes were transferred.

## Operation
- **Storage:** circular FIFO of 2^DEPTH_LOG2 bytes with read/write pointers that wrap modulo depth, plus a count register. It feeds a single output register (`tx_data_out`/`tx_valid_out`).
- **States:**
  - RUN (reset state).
  - DRAIN: entered on a write at offset 4 while in RUN.
  - DONE: entered from DRAIN when count==0 and `tx_valid_out`==0.
  - DONE is terminal until reset.
- **Push:** `rdy_in && io_wr_in && io_addr_in==0 && state==RUN && count<DEPTH` writes `io_data_in` at the write pointer and increments the pointer.
- **Dropped character writes:**
  - A character write with count==DEPTH, or in state DRAIN/DONE, is discarded and sets `overflow_out`.
  - Writes at offset 4 outside RUN are ignored without error.
  - Writes at any other offset are ignored.
- **Output register load:** when `rdy_in` is high, count>0, and either `tx_valid_out`==0 or (`tx_valid_out && tx_ready_in`), the head byte moves into `tx_data_out`, `tx_valid_out` is set, and the read pointer advances.
- **Output register clear:** on `tx_valid_out && tx_ready_in` with count==0, `tx_valid_out` clears.
- **Handshake stability:** while `tx_valid_out && !tx_ready_in`, `tx_data_out` and `tx_valid_out` hold stable.
- **Count update:** a push and a pop in the same cycle leave count unchanged. `io_full_out` = (count==DEPTH) and is combinational from the count register.
- **Full boundary:** no write-through bypass at full; a write in a cycle where count==DEPTH is dropped even if a pop occurs in that same cycle.
- **Pause:** `rdy_in` low freezes pointers, count, state and output register; a `tx_ready_in` pulse during that cycle transfers nothing.

## Timing
- **Reset values:**
  - `tx_data_out`=0, `tx_valid_out`=0, `count_out`=0, `io_full_out`=0, `overflow_out`=0, `done_out`=0.
  - State RUN, pointers 0.
  - Reset mid-operation flushes all queued bytes and any pending output without transfer.
- **Latency:** a character pushed at edge E into an empty buffer with idle output gives `tx_valid_out` high after edge E+1. Count reads 1 after E and 0 after E+1.
- **Throughput:** with `tx_ready_in` held high, one byte per cycle is sustained.
- **done_out:** rises on the edge after the cycle in which DRAIN observes count==0 and `tx_valid_out`==0. If offset 4 is written with an empty buffer, `done_out` is high two edges after the write edge.
- **Sticky flags:** `overflow_out` rises on the edge of the dropped write. `overflow_out` and `done_out` stay high until reset.

## Test plan
- **Single byte:** reset, write 0x41 at offset 0, hold `tx_ready_in`=1 → `tx_valid_out`=1 with `tx_data_out`=0x41 for exactly one cycle, one edge after the write; `count_out` returns to 0.
- **Back-pressure:** hold `tx_ready_in`=0 and write 17 bytes 0x00..0x10 (DEPTH_LOG2=4) → the first byte sits in the output register, 16 fill the FIFO, `io_full_out`=1 and `overflow_out` stays 0. A further write sets `overflow_out`=1. Releasing ready drains 0x00..0x10 in order with wrap-around intact.
- **Simultaneous push/pop:** with ready high and steady writes every cycle, count stays constant and the byte order is preserved.
- **Program end:** write "OK" then offset 4 with `tx_ready_in`=0; a later write at offset 0 sets `overflow_out` and is not sent. Releasing ready transfers 'O','K' and then raises `done_out`; offset 4 on an empty buffer gives `done_out` two edges later.
- **Pause:** drop `rdy_in` for 3 cycles while `tx_ready_in`=1 and data is pending → no transfer, all outputs frozen; normal transfer resumes when `rdy_in` returns high.
- **Reset mid-drain:** assert `rst_in` with 5 bytes queued → after the edge, all outputs are at reset values, and the next write behaves as on a fresh reset.
